// File: rtl/uart_wb_arbiter.sv
// Two-master Wishbone classic arbiter in front of the UART register port.
// Optional grant timeout is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_wb_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [AW-1:0]     m0_addr_i,
  input  logic [DW-1:0]     m0_wdata_i,
  input  logic [DW/8-1:0]   m0_sel_i,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic [DW-1:0]     m0_rdata_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [AW-1:0]     m1_addr_i,
  input  logic [DW-1:0]     m1_wdata_i,
  input  logic [DW/8-1:0]   m1_sel_i,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [DW-1:0]     m1_rdata_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [AW-1:0]     s_addr_o,
  output logic [DW-1:0]     s_wdata_o,
  output logic [DW/8-1:0]   s_sel_o,
  input  logic              s_ack_i,
  input  logic [DW-1:0]     s_rdata_i,
  output logic [1:0]        grant_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   req0, req1, gsel, reqx, ack_x, timeout_hit;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;
  assign gsel = (state_q == GNT1);
  assign reqx = gsel ? req1 : req0;

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] tcnt_q, tcnt_d;

  // IDLE always precedes a grant, so clearing there covers entry to GNTx.
  always_comb begin
    tcnt_d = tcnt_q;
    if (state_q == IDLE) begin
      tcnt_d = '0;
    end else if (!s_ack_i) begin
      tcnt_d = tcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  assign timeout_hit = (state_q != IDLE) && reqx && !s_ack_i && (tcnt_q == TO_LIMIT);
`else
  logic unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    s_cyc_o      = 1'b0;
    s_stb_o      = 1'b0;
    s_we_o       = 1'b0;
    s_addr_o     = '0;
    s_wdata_o    = '0;
    s_sel_o      = '0;
    m0_ack_o     = 1'b0;
    m0_err_o     = 1'b0;
    m0_rdata_o   = '0;
    m1_ack_o     = 1'b0;
    m1_err_o     = 1'b0;
    m1_rdata_o   = '0;
    ack_x        = 1'b0;

    unique case (state_q)
      IDLE: begin
        // On a tie the master that did not own the last grant wins.
        if (req0 && (!req1 || last_grant_q)) begin
          state_d      = GNT0;
          last_grant_d = 1'b0;
        end else if (req1) begin
          state_d      = GNT1;
          last_grant_d = 1'b1;
        end
      end
      GNT0, GNT1: begin
        s_cyc_o   = gsel ? m1_cyc_i   : m0_cyc_i;
        s_stb_o   = gsel ? m1_stb_i   : m0_stb_i;
        s_we_o    = gsel ? m1_we_i    : m0_we_i;
        s_addr_o  = gsel ? m1_addr_i  : m0_addr_i;
        s_wdata_o = gsel ? m1_wdata_i : m0_wdata_i;
        s_sel_o   = gsel ? m1_sel_i   : m0_sel_i;
        if (timeout_hit) begin
          s_cyc_o = 1'b0;
          s_stb_o = 1'b0;
        end
        // An abort in the ack cycle swallows the ack.
        ack_x = s_ack_i & reqx;
        if (gsel) begin
          m1_ack_o   = ack_x;
          m1_err_o   = timeout_hit;
          m1_rdata_o = timeout_hit ? '0 : s_rdata_i;
        end else begin
          m0_ack_o   = ack_x;
          m0_err_o   = timeout_hit;
          m0_rdata_o = timeout_hit ? '0 : s_rdata_i;
        end
        if (!reqx || s_ack_i || timeout_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_o = {state_q == GNT1, state_q == GNT0};
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_wb_arbiter.sv
// Scoreboard bench for uart_wb_arbiter: directed corner cases plus random two-master traffic.
module tb_uart_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc [2];
  logic        stb [2];
  logic        we [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [3:0]  sel [2];
  logic        mack [2];
  logic        merr [2];
  logic [31:0] mrdata [2];
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic [3:0]  s_sel_o;
  logic        s_ack;
  logic [31:0] s_rdata;
  logic [1:0]  grant_o;
  logic        busy_o;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } txn_t;

  txn_t q0[$];
  txn_t q1[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_lat = 1'b0;

  always #5 clk = ~clk;

  uart_wb_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]),
    .m0_wdata_i(wdata[0]), .m0_sel_i(sel[0]),
    .m0_ack_o(mack[0]), .m0_err_o(merr[0]), .m0_rdata_o(mrdata[0]),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]),
    .m1_wdata_i(wdata[1]), .m1_sel_i(sel[1]),
    .m1_ack_o(mack[1]), .m1_err_o(merr[1]), .m1_rdata_o(mrdata[1]),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_wdata_o(s_wdata_o), .s_sel_o(s_sel_o),
    .s_ack_i(s_ack), .s_rdata_i(s_rdata),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  function automatic logic [31:0] uart_data(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic bit mapped(input logic [31:0] a);
    return a[15:12] != 4'hF;
  endfunction

  // UART register port: registered ack after 0..2 wait states, never for unmapped addresses.
  int wcnt, lat;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack <= 1'b0; s_rdata <= '0; wcnt <= 0; lat <= 0;
    end else begin
      s_ack   <= 1'b0;
      s_rdata <= $urandom;
      if (s_cyc_o && s_stb_o && !s_ack && mapped(s_addr_o)) begin
        if (wcnt >= lat) begin
          s_ack   <= 1'b1;
          s_rdata <= uart_data(s_addr_o);
          wcnt    <= 0;
          lat     <= rand_lat ? int'($urandom_range(0, 2)) : 0;
        end else begin
          wcnt <= wcnt + 1;
        end
      end else if (!(s_cyc_o && s_stb_o)) begin
        wcnt <= 0;
        lat  <= rand_lat ? int'($urandom_range(0, 2)) : 0;
      end
    end
  end

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic ceq(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(act === exp, name, act, exp);
  endtask

  task automatic sb(input int m);
    txn_t t;
    bit   have;
    have = 1'b0;
    if (m == 0 && q0.size() > 0) begin t = q0.pop_front(); have = 1'b1; end
    if (m == 1 && q1.size() > 0) begin t = q1.pop_front(); have = 1'b1; end
    if (!have) begin
      chk(1'b0, "unexpected_ack", 32'(m), 32'hFFFF_FFFF);
    end else if (t.we) begin
      chk(s_we_o && s_addr_o == t.addr && s_sel_o == t.sel && s_wdata_o == t.wdata,
          "write_txn", s_wdata_o, t.wdata);
    end else begin
      chk(!s_we_o && s_addr_o == t.addr && s_sel_o == t.sel && mrdata[m] == uart_data(t.addr),
          "read_txn", mrdata[m], uart_data(t.addr));
    end
  endtask

  // Monitor: bus-level rules, round-robin expectation and the scoreboard.
  logic [1:0] prev_grant, prev_req, exp_g;
  bit         last_win, skip_arb, prev_end, ok;
  int         g;
  always @(negedge clk) begin
    if (!rst_n) begin
      last_win = 1'b1; skip_arb = 1'b1; prev_end = 1'b0; prev_grant = '0;
    end else begin
      if (grant_o == 2'b00) begin
        chk({busy_o, s_cyc_o, s_stb_o, s_we_o, mack[0], mack[1], merr[0], merr[1]} == '0 &&
            s_addr_o == '0 && s_wdata_o == '0 && s_sel_o == '0 && mrdata[0] == '0 && mrdata[1] == '0,
            "idle_outputs_zero", s_addr_o | s_wdata_o | mrdata[0] | mrdata[1], 32'd0);
      end else if (grant_o == 2'b01 || grant_o == 2'b10) begin
        g  = grant_o[1] ? 1 : 0;
        ok = busy_o && s_cyc_o == cyc[g] && s_stb_o == stb[g] && s_we_o == we[g] &&
             s_addr_o == addr[g] && s_wdata_o == wdata[g] && s_sel_o == sel[g] &&
             mack[g] == (s_ack && cyc[g] && stb[g]) && mrdata[g] == s_rdata &&
             !mack[1-g] && !merr[1-g] && mrdata[1-g] == '0;
`ifdef UART_ARB_TIMEOUT_EN
        if (merr[g]) ok = !s_cyc_o && !s_stb_o && !mack[g] && mrdata[g] == '0 &&
                          !mack[1-g] && !merr[1-g] && mrdata[1-g] == '0;
`else
        ok = ok && !merr[0] && !merr[1];
`endif
        chk(ok, "grant_mux", s_addr_o, addr[g]);
      end else begin
        chk(1'b0, "grant_onehot", 32'(grant_o), 32'd0);
      end
      if (prev_grant == 2'b00 && !skip_arb) begin
        if (prev_req == 2'b11) exp_g = last_win ? 2'b01 : 2'b10;
        else                   exp_g = prev_req;
        ceq("round_robin", 32'(grant_o), 32'(exp_g));
      end
      if (prev_grant == 2'b00 && grant_o != 2'b00) last_win = grant_o[1];
      if (prev_end) ceq("dead_cycle", 32'({grant_o, s_cyc_o}), 32'd0);
      if (mack[0]) sb(0);
      if (mack[1]) sb(1);
      prev_end   = mack[0] | mack[1] | merr[0] | merr[1];
      prev_grant = grant_o;
      skip_arb   = 1'b0;
    end
    prev_req = {cyc[1] & stb[1], cyc[0] & stb[0]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int m, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input bit push);
    txn_t t;
    cyc[m] = 1'b1; stb[m] = 1'b1; we[m] = w; addr[m] = a; wdata[m] = d; sel[m] = s;
    t.we = w; t.addr = a; t.wdata = d; t.sel = s;
    if (push && m == 0) q0.push_back(t);
    if (push && m == 1) q1.push_back(t);
  endtask

  task automatic idle(input int m);
    cyc[m] = 1'b0; stb[m] = 1'b0; we[m] = 1'b0; addr[m] = '0; wdata[m] = '0; sel[m] = '0;
  endtask

  task automatic wait_ack(input int m, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mack[m] && n < 64);
    chk(mack[m] === 1'b1, name, 32'(n), 32'd64);
  endtask

  task automatic all_zero(input string name);
    chk({grant_o, busy_o, s_cyc_o, s_stb_o, s_we_o, mack[0], mack[1], merr[0], merr[1]} == '0 &&
        s_addr_o == '0 && s_wdata_o == '0 && s_sel_o == '0 && mrdata[0] == '0 && mrdata[1] == '0,
        name, 32'({grant_o, busy_o, s_cyc_o, s_stb_o}), 32'd0);
  endtask

  task automatic drive_rand(input int m, input int n);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        idle(m);
        repeat (gap) tick();
      end
      req(m, 1'($urandom_range(0, 1)), {16'h0, 4'($urandom_range(0, 14)), 12'($urandom)},
          $urandom, 4'($urandom_range(1, 15)), 1'b1);
      wait_ack(m, m == 0 ? "rand_ack_m0" : "rand_ack_m1");
      tick();
    end
    idle(m);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    idle(0);
    idle(1);
    repeat (3) @(negedge clk);
    all_zero("reset_outputs");
    tick();
    rst_n = 1'b1;
    tick();

    // Single m0 read: grant at N+1, ack at N+2, dead cycle at N+3.
    tick();
    req(0, 1'b0, 32'h4, 32'h0, 4'hF, 1'b1);
    @(negedge clk) ceq("t1_idle_N", 32'(grant_o), 32'd0);
    @(negedge clk) ceq("t1_grant_N1", 32'({grant_o, s_cyc_o, s_stb_o}), 32'b0111);
    @(negedge clk) ceq("t1_ack_N2", 32'(mack[0]), 32'd1);
    ceq("t1_rdata_N2", mrdata[0], uart_data(32'h4));
    tick();
    idle(0);
    @(negedge clk) ceq("t1_dead_N3", 32'({s_cyc_o, busy_o}), 32'd0);

    // m1 write of 0x41 to the TX register.
    tick();
    req(1, 1'b1, 32'h0, 32'h41, 4'b0001, 1'b1);
    wait_ack(1, "t3_ack");
    ceq("t3_write_bus", 32'({s_we_o, s_sel_o}), 32'b10001);
    ceq("t3_wdata", s_wdata_o, 32'h41);
    ceq("t3_m0_quiet", 32'({mack[0], mrdata[0] != '0}), 32'd0);
    tick();
    idle(1);
    @(negedge clk) ceq("t3_single_pulse", 32'(mack[1]), 32'd0);

    // Tie goes to m0, which aborts right after the grant; m1 follows.
    tick();
    req(0, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0);
    req(1, 1'b0, 32'hC, 32'h0, 4'hF, 1'b1);
    @(negedge clk);
    tick();
    idle(0);
    @(negedge clk) ceq("t4_grant_m0", 32'({grant_o, s_cyc_o}), 32'b010);
    @(negedge clk) ceq("t4_abort_idle", 32'({busy_o, s_cyc_o, mack[0]}), 32'd0);
    @(negedge clk) ceq("t4_m1_next", 32'(grant_o), 32'b10);
    wait_ack(1, "t4_m1_ack");
    tick();
    idle(1);

    // Abort in the same cycle as the UART ack: ack is dropped.
    tick();
    req(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
    tick();
    tick();
    idle(0);
    @(negedge clk) ceq("t5_ack_dropped", 32'({s_ack, mack[0]}), 32'b10);
    @(negedge clk) ceq("t5_idle", 32'(busy_o), 32'd0);

    // Unmapped m0 access with m1 waiting behind it.
    tick();
    req(0, 1'b0, 32'hF000, 32'h0, 4'hF, 1'b0);
    tick();
    @(negedge clk) ceq("t6_grant", 32'(grant_o), 32'b01);
    tick();
    req(1, 1'b0, 32'h14, 32'h0, 4'hF, 1'b1);
`ifdef UART_ARB_TIMEOUT_EN
    repeat (3) @(negedge clk) ceq("t6_no_err_yet", 32'(merr[0]), 32'd0);
    @(negedge clk) ceq("t6_timeout_err", 32'({merr[0], mack[0], s_cyc_o}), 32'b100);
    ceq("t6_err_rdata", mrdata[0], 32'd0);
`else
    repeat (10) @(negedge clk) ceq("t6_hold", 32'({grant_o, mack[0], merr[0]}), 32'b0100);
`endif
    tick();
    idle(0);
    wait_ack(1, "t6_m1_ack");
    tick();
    idle(1);

    // Random concurrent traffic from both masters.
    rand_lat = 1'b1;
    fork
      drive_rand(0, 150);
      drive_rand(1, 150);
    join
    rand_lat = 1'b0;
    repeat (3) tick();

    // Asynchronous reset while m1 holds the grant, then first tie to m0.
    tick();
    req(1, 1'b0, 32'hF004, 32'h0, 4'hF, 1'b0);
    tick();
    @(negedge clk) ceq("t8_gnt1", 32'(grant_o), 32'b10);
    #2 rst_n = 1'b0;
    #1 all_zero("t8_async_reset");
    tick();
    req(0, 1'b0, 32'h18, 32'h0, 4'hF, 1'b1);
    req(1, 1'b0, 32'h1C, 32'h0, 4'hF, 1'b1);
    tick();
    rst_n = 1'b1;
    @(negedge clk) ceq("t8_idle_after_release", 32'(grant_o), 32'd0);
    @(negedge clk) ceq("t8_first_tie_m0", 32'(grant_o), 32'b01);
    wait_ack(0, "t8_m0_ack");
    tick();
    idle(0);
    wait_ack(1, "t8_m1_ack");
    tick();
    idle(1);
    repeat (3) tick();

    ceq("queues_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
